// File: rtl/mult_host_pkg.sv
// Shared types and constants for the multiply-stream self-test host.
package mult_host_pkg;

    localparam int CNT_W = 16;
    localparam int OP_W  = 8;

    localparam logic [CNT_W-1:0] NO_ERR_IDX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mult_operand_gen.sv
// Maps a stream index to its operand word {a,b} and the expected unsigned product.
module mult_operand_gen
    import mult_host_pkg::*;
#(
    parameter logic [OP_W-1:0] B_XOR = 8'hFF,
    parameter logic [OP_W-1:0] A_OFS = 8'h00
) (
    input  logic [OP_W-1:0]   idx,
    output logic [2*OP_W-1:0] op,
    output logic [2*OP_W-1:0] expected
);

    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;

    assign a        = idx + A_OFS;
    assign b        = idx ^ B_XOR;
    assign op       = {a, b};
    assign expected = (2*OP_W)'(a) * (2*OP_W)'(b);

endmodule

// File: rtl/mult_stream_host.sv
// Self-test master for the 8x8 multiply stream: feeds operand words, drains and
// checks products, and reports error count, first failing index and watchdog abort.
module mult_stream_host
    import mult_host_pkg::*;
#(
    parameter logic [OP_W-1:0] B_XOR   = 8'hFF,
    parameter logic [OP_W-1:0] A_OFS   = 8'h00,
    parameter int              TIMEOUT = 1024
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [CNT_W-1:0]    NUM,
    output logic                BUSY,
    output logic                DONE,
    output logic                TIMEOUT_ERR,
    output logic [CNT_W-1:0]    ERR_CNT,
    output logic [CNT_W-1:0]    FIRST_ERR_IDX,
    output logic [2*OP_W-1:0]   OP_DATA,
    output logic                OP_WR,
    input  logic                OP_FULL,
    input  logic [2*OP_W-1:0]   RES_DATA,
    input  logic                RES_VALID,
    input  logic                RES_EMPTY,
    output logic                RES_RD
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  chk_idx;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  first_err_idx;
    logic [WD_W-1:0]   wdog;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;

    logic [2*OP_W-1:0] wr_op;
    logic [2*OP_W-1:0] wr_exp;
    logic [2*OP_W-1:0] chk_op;
    logic [2*OP_W-1:0] chk_exp;
    logic              gen_unused;

    logic in_run;
    logic op_wr;
    logic res_rd;
    logic chk_pending;
    logic chk_hit;
    logic extra_word;
    logic mismatch;
    logic start_ok;
    logic wd_expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    mult_operand_gen #(.B_XOR(B_XOR), .A_OFS(A_OFS)) u_wr_gen (
        .idx      (wr_idx[OP_W-1:0]),
        .op       (wr_op),
        .expected (wr_exp)
    );

    mult_operand_gen #(.B_XOR(B_XOR), .A_OFS(A_OFS)) u_chk_gen (
        .idx      (chk_idx[OP_W-1:0]),
        .op       (chk_op),
        .expected (chk_exp)
    );

    // Each generator instance only needs half of its outputs.
    assign gen_unused = ^{wr_exp, chk_op};

    assign in_run      = (state == RUN);
    assign op_wr       = in_run & ~OP_FULL & (wr_idx < num_q);
    assign res_rd      = in_run & ~RES_EMPTY & (rd_cnt < num_q);
    assign chk_pending = (chk_idx < num_q);
    assign chk_hit     = RES_VALID & in_run & chk_pending;
    assign extra_word  = RES_VALID & ~chk_hit;
    assign mismatch    = chk_hit & (RES_DATA != chk_exp);
    assign start_ok    = START & ((state == IDLE) | (state == FINISH));
    assign wd_expire   = in_run & chk_pending & ~RES_VALID & (wdog == WD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            num_q         <= '0;
            wr_idx        <= '0;
            rd_cnt        <= '0;
            chk_idx       <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR_IDX;
            wdog          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start_ok) begin
                        state     <= RUN;
                        num_q     <= NUM;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!chk_pending) begin
                        state  <= FINISH;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (wd_expire) begin
                        state     <= FINISH;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase

            // Strobes and checks only fire in RUN, so they never collide with a restart.
            if (start_ok) begin
                wr_idx  <= '0;
                rd_cnt  <= '0;
                chk_idx <= '0;
            end else begin
                if (op_wr)   wr_idx  <= wr_idx + CNT_W'(1);
                if (res_rd)  rd_cnt  <= rd_cnt + CNT_W'(1);
                if (chk_hit) chk_idx <= chk_idx + CNT_W'(1);
            end

            // Extra words bump the count but never claim a first-failure index.
            if (start_ok) begin
                err_cnt       <= '0;
                first_err_idx <= NO_ERR_IDX;
            end else begin
                if (mismatch || extra_word) err_cnt <= sat_inc(err_cnt);
                if (mismatch && (first_err_idx == NO_ERR_IDX)) first_err_idx <= chk_idx;
            end

            if (start_ok || RES_VALID) wdog <= '0;
            else if (in_run && chk_pending) wdog <= wdog + WD_W'(1);
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign TIMEOUT_ERR   = timeout_q;
    assign ERR_CNT       = err_cnt;
    assign FIRST_ERR_IDX = first_err_idx;
    assign OP_DATA       = wr_op;
    assign OP_WR         = op_wr;
    assign RES_RD        = res_rd;

endmodule

// File: doc/mult_stream_host.md
Name: mult_stream_host

Overview:
- Host-side driver/checker for the 8x8 multiply stream pipeline.
- Write side: generates packed operand words {a,b} into the pipeline input FIFO, honouring FULL.
- Read side: drains 16-bit products from the output FIFO via RD/VALID/EMPTY and checks each against a locally recomputed expected product.
- Reports completion, error count, first failing index and timeout; serves as the on-chip self-test master for the multiplier pipeline.

Parameters:
- B_XOR, 8'hFF: XOR mask for operand b; b = idx[7:0] ^ B_XOR.
- A_OFS, 8'h00: additive offset for operand a; a = idx[7:0] + A_OFS, mod 256.
- TIMEOUT, 1024: cycles without RES_VALID in RUN (results outstanding) before abort.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  single-cycle start request; sampled in IDLE or FINISH.
- NUM  in  16  number of operand pairs; captured on accepted START.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in FINISH, held until next accepted START or RST.
- TIMEOUT_ERR  out  1  run ended by watchdog; valid while DONE.
- ERR_CNT  out  16  mismatching results; saturates at 16'hFFFF.
- FIRST_ERR_IDX  out  16  index of first mismatch; 16'hFFFF if none.
- OP_DATA  out  16  {a[7:0], b[7:0]} to pipeline DIN.
- OP_WR  out  1  write strobe to pipeline.
- OP_FULL  in  1  pipeline input FIFO full.
- RES_DATA  in  16  product from pipeline DOUT.
- RES_VALID  in  1  RES_DATA valid this cycle.
- RES_EMPTY  in  1  pipeline output FIFO empty.
- RES_RD  out  1  read strobe to pipeline.

Behaviour:
- Reset (async, any state, including mid-run): state IDLE; wr_idx, rd_cnt, chk_idx = 0; ERR_CNT = 0; FIRST_ERR_IDX = 16'hFFFF; BUSY, DONE, TIMEOUT_ERR = 0; OP_WR, RES_RD = 0.
- States:
  - IDLE: START -> RUN, capture NUM.
  - RUN:
    - chk_idx == num_q -> FINISH.
    - Watchdog expiry -> FINISH with TIMEOUT_ERR = 1.
    - START ignored.
  - FINISH: START -> RUN; on the same edge clear counters/errors and capture the new NUM.
- NUM = 0 on START: RUN for exactly 1 cycle, then FINISH. No OP_WR, no RES_RD.
- Write side (combinational from registered state):
  - OP_WR = RUN & ~OP_FULL & (wr_idx < num_q).
  - OP_DATA = gen(wr_idx).
  - wr_idx increments on every OP_WR cycle.
  - Back-to-back writes at 1/cycle while not full.
  - FULL asserted -> OP_WR low the same cycle; OP_DATA holds the current index.
- Read side:
  - RES_RD = RUN & ~RES_EMPTY & (rd_cnt < num_q).
  - rd_cnt increments per RES_RD; never reads past NUM.
  - Data is consumed only on RES_VALID, which occurs any cycles after RD; order is preserved.
- Check, on RES_VALID in RUN with chk_idx < num_q:
  - expected = a*b, unsigned 8x8 -> 16 bits, from gen(chk_idx).
  - Mismatch: ERR_CNT += 1 (saturating); if FIRST_ERR_IDX == 16'hFFFF, load chk_idx.
  - chk_idx increments.
- RES_VALID outside RUN, or with chk_idx == num_q: the data is an extra word, counted as one error; FIRST_ERR_IDX is unchanged.
- Watchdog:
  - Counter clears on RES_VALID and on entering RUN.
  - Increments each RUN cycle while chk_idx < num_q.
  - Reaching TIMEOUT -> FINISH.
- Simultaneous OP_WR, RES_RD and RES_VALID in one cycle are legal and independent.
- Latency, START to first OP_WR: 1 cycle, the first RUN cycle.
- Counters are 16-bit; wr_idx <= NUM <= 65535, so no wrap. idx[7:0] wraps naturally for operands.

Decomposition:
- Package mult_host_pkg:
  - state enum IDLE/RUN/FINISH.
  - CNT_W = 16, OP_W = 8.
  - NO_ERR_IDX = 16'hFFFF.
- Sub-module mult_operand_gen: combinational idx -> {a,b,expected}. Two instances: write index and check index.

Test Plan:
- NUM=4, pipeline never full, defaults -> OP_DATA = 16'h00FF, 16'h01FE, 16'h02FD, 16'h03FC on consecutive cycles; results 0, 254, 506, 756 checked; DONE=1, ERR_CNT=0, FIRST_ERR_IDX=16'hFFFF.
- NUM=300, bench holds OP_FULL high for 20-cycle bursts -> no OP_WR while full; exactly 300 writes and 300 reads; DONE with ERR_CNT=0.
- NUM=8, model corrupts result idx 3 (XOR 16'h0001) and idx 6 -> ERR_CNT=2, FIRST_ERR_IDX=3.
- NUM=5, model drops the last result -> after TIMEOUT=1024 idle cycles, DONE=1, TIMEOUT_ERR=1, ERR_CNT=0.
- RST pulsed mid-run at wr_idx=10, then NUM=0 START -> outputs at reset values immediately; the following run gives DONE 2 cycles after START, no strobes.
- START during RUN ignored; START in FINISH restarts with counters cleared and DONE low the next cycle.
